// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI burst/response encodings and channel FSM state types
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // WRAP (10) and the reserved code (11) are serviced as INCR but flagged SLVERR
  function automatic logic burst_is_unsupported(input logic [1:0] burst);
    return burst[1];
  endfunction

endpackage

// File: rtl/axi_sp_ram_be.sv
// rtl/axi_sp_ram_be.sv - word RAM with byte-enable write port and registered read port
module axi_sp_ram_be #(
  parameter int  DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_strb,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;
  logic [31:0] rd_data_d;

  // Byte-strobed write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Read register loads only when asked, otherwise holds (keeps RDATA stable under stall)
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_idx];
    end
  end

  // Read data register; a same-edge write to the same word is not visible here (read-first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= 32'h0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi4_full_slave_mem.sv
// rtl/axi4_full_slave_mem.sv - AXI4 slave memory servicing INCR/FIXED bursts on independent read and write channels
module axi4_full_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [1:0]            AWBURST,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [31:0]           WDATA,
  input  logic [3:0]            WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int               IDX_W   = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  // Write channel state
  w_state_t         w_state_q, w_state_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic [7:0]       wlen_q, wlen_d;
  logic             wfixed_q, wfixed_d;
  logic             werr_q, werr_d;
  logic [8:0]       wcnt_q, wcnt_d;
  logic [1:0]       bresp_q, bresp_d;

  // Read channel state
  r_state_t         r_state_q, r_state_d;
  logic [IDX_W-1:0] ridx_q, ridx_d;
  logic [7:0]       rlen_q, rlen_d;
  logic [7:0]       rbeat_q, rbeat_d;
  logic             rfixed_q, rfixed_d;
  logic             rlast_q, rlast_d;
  logic [1:0]       rresp_q, rresp_d;

  // RAM port controls
  logic             ram_we;
  logic             ram_re;
  logic [IDX_W-1:0] ram_ridx;
  logic [IDX_W-1:0] next_ridx;
  logic [31:0]      ram_rdata;

  // Only the word index bits of the addresses select storage
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[1:0], AWADDR[ADDR_WIDTH-1:IDX_W+2],
                              ARADDR[1:0], ARADDR[ADDR_WIDTH-1:IDX_W+2]};

  // Write FSM: accept address, absorb beats (writing only those within AWLEN), then respond
  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wfixed_d  = wfixed_q;
    werr_d    = werr_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    ram_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID) begin
          widx_d    = AWADDR[2 +: IDX_W];
          wlen_d    = AWLEN;
          wfixed_d  = (AWBURST == BURST_FIXED);
          werr_d    = burst_is_unsupported(AWBURST);
          wcnt_d    = 9'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID) begin
          ram_we = (wcnt_q <= {1'b0, wlen_q});
          if (!wfixed_q) begin
            widx_d = widx_q + IDX_ONE;
          end
          // Saturate so a runaway burst can never wrap back into the writable range
          if (wcnt_q != 9'h1FF) begin
            wcnt_d = wcnt_q + 9'd1;
          end
          if (WLAST) begin
            bresp_d   = ((wcnt_q != {1'b0, wlen_q}) || werr_q) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      widx_q    <= '0;
      wlen_q    <= 8'd0;
      wfixed_q  <= 1'b0;
      werr_q    <= 1'b0;
      wcnt_q    <= 9'd0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wfixed_q  <= wfixed_d;
      werr_q    <= werr_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
    end
  end

  assign next_ridx = rfixed_q ? ridx_q : (ridx_q + IDX_ONE);

  // Read FSM: prefetch the first word on AR, then fetch the next word on each accepted beat
  always_comb begin
    r_state_d = r_state_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    rfixed_d  = rfixed_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    ram_re    = 1'b0;
    ram_ridx  = ridx_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          ram_re    = 1'b1;
          ram_ridx  = ARADDR[2 +: IDX_W];
          ridx_d    = ARADDR[2 +: IDX_W];
          rlen_d    = ARLEN;
          rbeat_d   = 8'd0;
          rfixed_d  = (ARBURST == BURST_FIXED);
          rlast_d   = (ARLEN == 8'd0);
          rresp_d   = burst_is_unsupported(ARBURST) ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            ram_re   = 1'b1;
            ram_ridx = next_ridx;
            ridx_d   = next_ridx;
            rbeat_d  = rbeat_q + 8'd1;
            rlast_d  = ((rbeat_q + 8'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      ridx_q    <= '0;
      rlen_q    <= 8'd0;
      rbeat_q   <= 8'd0;
      rfixed_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rbeat_q   <= rbeat_d;
      rfixed_q  <= rfixed_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  axi_sp_ram_be #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .wr_en   (ram_we),
    .wr_idx  (widx_q),
    .wr_data (WDATA),
    .wr_strb (WSTRB),
    .rd_en   (ram_re),
    .rd_idx  (ram_ridx),
    .rd_data (ram_rdata)
  );

  assign AWREADY = (w_state_q == W_IDLE);
  assign WREADY  = (w_state_q == W_DATA);
  assign BVALID  = (w_state_q == W_RESP);
  assign BRESP   = bresp_q;

  assign ARREADY = (r_state_q == R_IDLE);
  assign RVALID  = (r_state_q == R_DATA);
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;
  assign RDATA   = ram_rdata;

endmodule

// File: tb/tb_axi4_full_slave_mem.sv
// tb/tb_axi4_full_slave_mem.sv - randomized self-checking bench for axi4_full_slave_mem
module tb_axi4_full_slave_mem;

  localparam int DEPTH = 1024;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  int checks   = 0;
  int failures = 0;

  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] wd [0:511];
  logic [3:0]  ws [0:511];
  logic [31:0] rd [0:511];

  always #5 ACLK = ~ACLK;

  axi4_full_slave_mem #(.ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference: beat i of a burst hits word start (FIXED) or start+i mod DEPTH (everything else)
  function automatic int beat_word(input logic [31:0] addr, input logic [1:0] burst, input int i);
    int base;
    base = int'(addr[11:2]);
    return (burst == 2'b00) ? base : (base + i) % DEPTH;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      if (i <= int'(len)) begin
        for (int b = 0; b < 4; b++) begin
          if (ws[i][b]) ref_mem[beat_word(addr, burst, i)][8*b +: 8] = wd[i][8*b +: 8];
        end
      end
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input int nbeats, input bit gaps, output logic [1:0] resp);
    int cyc, i;
    logic v, br, got;
    resp = 2'bxx;
    AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1; cyc = 0;
    while (AWREADY !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    checks++;
    if (AWREADY !== 1'b1) begin
      failures++; $display("FAIL aw_handshake AWREADY=%b required 1", AWREADY);
      AWVALID = 1'b0; return;
    end
    tick(); AWVALID = 1'b0; i = 0; cyc = 0;
    while (i < nbeats && cyc < 2000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      WVALID = v; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == nbeats - 1);
      if (v && WREADY === 1'b1) i++;
      tick(); cyc++;
    end
    WVALID = 1'b0; WLAST = 1'b0; got = 1'b0; cyc = 0;
    while (!got && cyc < 100) begin
      br = gaps ? ($urandom_range(0, 1) != 0) : 1'b1;
      BREADY = br;
      if (BVALID === 1'b1 && br) begin resp = BRESP; got = 1'b1; end
      tick(); cyc++;
    end
    BREADY = 1'b0;
    checks++;
    if (!got) begin failures++; $display("FAIL b_handshake beats_sent=%0d of %0d, no BVALID", i, nbeats); end
  endtask

  // mode 0: RREADY high, 1: toggles every cycle starting low, 2: random
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input int mode, output int n, output int last_pos, output logic [1:0] resp0,
                          output int resp_diff, output int hold_errs, output logic first_valid,
                          output logic rvalid_after);
    int cyc;
    logic rr, prev_stall, done, pl;
    logic [31:0] pd;
    logic [1:0] pr;
    n = 0; last_pos = -1; resp0 = 2'bxx; resp_diff = 0; hold_errs = 0;
    first_valid = 1'b0; rvalid_after = 1'b1;
    prev_stall = 1'b0; done = 1'b0; pd = '0; pl = 1'b0; pr = '0;
    ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1; cyc = 0;
    while (ARREADY !== 1'b1 && cyc < 50) begin tick(); cyc++; end
    checks++;
    if (ARREADY !== 1'b1) begin
      failures++; $display("FAIL ar_handshake ARREADY=%b required 1", ARREADY);
      ARVALID = 1'b0; return;
    end
    tick(); ARVALID = 1'b0; first_valid = RVALID; cyc = 0;
    while (!done && cyc < 2000 && n < 300) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) != 0) : ($urandom_range(0, 2) != 0);
      RREADY = rr;
      if (prev_stall && ({RVALID, RDATA, RLAST, RRESP} !== {1'b1, pd, pl, pr})) hold_errs++;
      prev_stall = 1'b0;
      if (RVALID === 1'b1) begin
        if (rr) begin
          rd[n] = RDATA;
          if (n == 0) resp0 = RRESP; else if (RRESP !== resp0) resp_diff++;
          n++;
          if (RLAST === 1'b1) begin last_pos = n; done = 1'b1; end
        end else begin
          prev_stall = 1'b1; pd = RDATA; pl = RLAST; pr = RRESP;
        end
      end
      tick(); cyc++;
    end
    RREADY = 1'b0;
    rvalid_after = RVALID;
    checks++;
    if (!done) begin failures++; $display("FAIL r_burst_end beats=%0d, no RLAST handshake", n); end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) tick();
    checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST} !== 6'b110000) begin
      failures++; $display("FAIL reset_handshakes AW/AR/W/B/R/RLAST=%b required 110000",
                           {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST});
    end
    checks++;
    if ({BRESP, RRESP} !== 4'b0000) begin
      failures++; $display("FAIL reset_resp BRESP,RRESP=%b required 0000", {BRESP, RRESP});
    end
    checks++;
    if (RDATA !== 32'h0) begin failures++; $display("FAIL reset_rdata RDATA=%h required 0", RDATA); end
    ARESETn = 1'b1;
    tick();
    checks++;
    if ({AWREADY, ARREADY, RVALID, BVALID} !== 4'b1100) begin
      failures++; $display("FAIL post_reset_ready AW/AR/R/B=%b required 1100", {AWREADY, ARREADY, RVALID, BVALID});
    end
  endtask

  task automatic test_fill();
    logic [1:0] resp;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_write(32'(k * 1024), 8'd255, 2'b01, 256, 1'b0, resp);
      model_write(32'(k * 1024), 8'd255, 2'b01, 256);
      checks++;
      if (resp !== 2'b00) begin failures++; $display("FAIL fill_bresp chunk %0d BRESP=%b required 00", k, resp); end
    end
  endtask

  task automatic test_basic_incr();
    logic [1:0] resp, r0;
    int n, lp, rdiff, herr;
    logic fv, ra;
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    axi_write(32'h0, 8'd3, 2'b01, 4, 1'b0, resp);
    model_write(32'h0, 8'd3, 2'b01, 4);
    checks++;
    if (resp !== 2'b00) begin failures++; $display("FAIL basic_bresp BRESP=%b required 00", resp); end
    checks++;
    if (AWREADY !== 1'b1) begin failures++; $display("FAIL basic_awready_after_b AWREADY=%b required 1", AWREADY); end
    axi_read(32'h0, 8'd3, 2'b01, 0, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (fv !== 1'b1) begin failures++; $display("FAIL basic_read_latency RVALID after AR=%b required 1", fv); end
    checks++;
    if (n != 4 || lp != 4) begin failures++; $display("FAIL basic_rlast beats=%0d rlast_at=%0d required 4/4", n, lp); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (rd[i] !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL basic_rdata beat %0d got %h required %h", i, rd[i], 32'hA0 + 32'(i));
      end
    end
    checks++;
    if (r0 !== 2'b00 || ra !== 1'b0) begin
      failures++; $display("FAIL basic_rresp_end RRESP=%b RVALID_after=%b required 00/0", r0, ra);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp, r0;
    int n, lp, rdiff, herr;
    logic fv, ra;
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    axi_write(32'h10, 8'd0, 2'b01, 1, 1'b0, resp);
    model_write(32'h10, 8'd0, 2'b01, 1);
    wd[0] = 32'h0000_0000; ws[0] = 4'b0101;
    axi_write(32'h10, 8'd0, 2'b01, 1, 1'b0, resp);
    model_write(32'h10, 8'd0, 2'b01, 1);
    axi_read(32'h10, 8'd0, 2'b01, 0, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (n != 1 || rd[0] !== 32'hFF00_FF00) begin
      failures++; $display("FAIL strobe_merge beats=%0d got %h required 1 beat of ff00ff00", n, rd[0]);
    end
  endtask

  task automatic test_long_toggle();
    logic [1:0] r0;
    int n, lp, rdiff, herr, bad;
    logic fv, ra;
    logic [31:0] addr;
    addr = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
    axi_read(addr, 8'd255, 2'b01, 1, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (n != 256 || lp != 256) begin failures++; $display("FAIL long_beats beats=%0d rlast_at=%0d required 256/256", n, lp); end
    checks++;
    if (herr != 0) begin failures++; $display("FAIL long_stall_hold changed_while_stalled=%0d required 0", herr); end
    bad = 0;
    for (int i = 0; i < n && i < 256; i++) begin
      checks++;
      if (rd[i] !== ref_mem[beat_word(addr, 2'b01, i)]) begin
        failures++; bad++;
        if (bad < 5) $display("FAIL long_rdata beat %0d got %h required %h", i, rd[i], ref_mem[beat_word(addr, 2'b01, i)]);
      end
    end
  endtask

  task automatic test_wrap_fixed();
    logic [1:0] resp, r0;
    int n, lp, rdiff, herr;
    logic fv, ra;
    logic [31:0] d0, d1, d2, nb;
    d0 = $urandom; d1 = $urandom;
    wd[0] = d0; wd[1] = d1; ws[0] = 4'hF; ws[1] = 4'hF;
    axi_write(32'hFFC, 8'd1, 2'b01, 2, 1'b1, resp);
    model_write(32'hFFC, 8'd1, 2'b01, 2);
    axi_read(32'hFFC, 8'd0, 2'b01, 0, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (rd[0] !== d0) begin failures++; $display("FAIL wrap_word1023 got %h required %h", rd[0], d0); end
    axi_read(32'h0, 8'd0, 2'b01, 0, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (rd[0] !== d1) begin failures++; $display("FAIL wrap_word0 got %h required %h", rd[0], d1); end
    nb = ref_mem[17];
    for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    d2 = wd[2];
    axi_write(32'h40, 8'd2, 2'b00, 3, 1'b1, resp);
    model_write(32'h40, 8'd2, 2'b00, 3);
    axi_read(32'h40, 8'd1, 2'b01, 2, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (n != 2 || rd[0] !== d2 || rd[1] !== nb) begin
      failures++; $display("FAIL fixed_last_beat beats=%0d got %h,%h required %h,%h", n, rd[0], rd[1], d2, nb);
    end
  endtask

  task automatic test_wlast_mismatch();
    logic [1:0] resp, r0;
    int n, lp, rdiff, herr;
    logic fv, ra;
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(32'h200, 8'd3, 2'b01, 2, 1'b0, resp);
    model_write(32'h200, 8'd3, 2'b01, 2);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL short_burst_bresp BRESP=%b required 10", resp); end
    checks++;
    if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
      failures++; $display("FAIL short_burst_idle AWREADY=%b WREADY=%b required 1/0", AWREADY, WREADY);
    end
    for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(32'h300, 8'd1, 2'b01, 4, 1'b0, resp);
    model_write(32'h300, 8'd1, 2'b01, 4);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL long_burst_bresp BRESP=%b required 10", resp); end
    axi_read(32'h200, 8'd5, 2'b01, 0, n, lp, r0, rdiff, herr, fv, ra);
    for (int i = 0; i < 6 && i < n; i++) begin
      checks++;
      if (rd[i] !== ref_mem[beat_word(32'h200, 2'b01, i)]) begin
        failures++; $display("FAIL short_burst_mem beat %0d got %h required %h", i, rd[i], ref_mem[beat_word(32'h200, 2'b01, i)]);
      end
    end
    axi_read(32'h300, 8'd3, 2'b01, 0, n, lp, r0, rdiff, herr, fv, ra);
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++;
      if (rd[i] !== ref_mem[beat_word(32'h300, 2'b01, i)]) begin
        failures++; $display("FAIL extra_beats_mem beat %0d got %h required %h", i, rd[i], ref_mem[beat_word(32'h300, 2'b01, i)]);
      end
    end
  endtask

  task automatic test_reserved();
    logic [1:0] resp, r0;
    int n, lp, rdiff, herr;
    logic fv, ra;
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    axi_write(32'h400, 8'd1, 2'b10, 2, 1'b0, resp);
    model_write(32'h400, 8'd1, 2'b10, 2);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL wrap_burst_bresp BRESP=%b required 10", resp); end
    axi_read(32'h400, 8'd2, 2'b11, 2, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (n != 3 || r0 !== 2'b10 || rdiff != 0) begin
      failures++; $display("FAIL reserved_rresp beats=%0d RRESP=%b changes=%0d required 3/10/0", n, r0, rdiff);
    end
    for (int i = 0; i < 3 && i < n; i++) begin
      checks++;
      if (rd[i] !== ref_mem[beat_word(32'h400, 2'b01, i)]) begin
        failures++; $display("FAIL reserved_rdata beat %0d got %h required %h", i, rd[i], ref_mem[beat_word(32'h400, 2'b01, i)]);
      end
    end
  endtask

  task automatic test_concurrent();
    logic [1:0] r0;
    int n, lp, rdiff, herr;
    logic fv, ra;
    logic [31:0] old_v, new_v;
    old_v = ref_mem[100];
    new_v = ~old_v;
    AWADDR = 32'h190; AWLEN = 8'd0; AWBURST = 2'b01; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = new_v; WSTRB = 4'hF; WLAST = 1'b1;
    ARADDR = 32'h190; ARLEN = 8'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    checks++;
    if (WREADY !== 1'b1 || ARREADY !== 1'b1) begin
      failures++; $display("FAIL concurrent_setup WREADY=%b ARREADY=%b required 1/1", WREADY, ARREADY);
    end
    tick();
    WVALID = 1'b0; WLAST = 1'b0; ARVALID = 1'b0; RREADY = 1'b1; BREADY = 1'b1;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== old_v || RLAST !== 1'b1) begin
      failures++; $display("FAIL concurrent_read_first RVALID=%b RLAST=%b got %h required 1/1/%h", RVALID, RLAST, RDATA, old_v);
    end
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      failures++; $display("FAIL concurrent_bresp BVALID=%b BRESP=%b required 1/00", BVALID, BRESP);
    end
    tick();
    RREADY = 1'b0; BREADY = 1'b0;
    ref_mem[100] = new_v;
    axi_read(32'h190, 8'd0, 2'b01, 0, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (rd[0] !== new_v) begin failures++; $display("FAIL concurrent_new_value got %h required %h", rd[0], new_v); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] r0;
    int n, lp, rdiff, herr;
    logic fv, ra;
    ARADDR = 32'h800; ARLEN = 8'd7; ARBURST = 2'b01; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0; RREADY = 1'b1;
    tick(); tick();
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if (RVALID !== 1'b0 || RLAST !== 1'b0) begin
      failures++; $display("FAIL reset_mid_rvalid RVALID=%b RLAST=%b required 0/0", RVALID, RLAST);
    end
    RREADY = 1'b0;
    tick(); tick();
    ARESETn = 1'b1;
    tick();
    checks++;
    if (ARREADY !== 1'b1 || AWREADY !== 1'b1 || RVALID !== 1'b0) begin
      failures++; $display("FAIL reset_mid_release ARREADY=%b AWREADY=%b RVALID=%b required 1/1/0", ARREADY, AWREADY, RVALID);
    end
    axi_read(32'h800, 8'd1, 2'b01, 0, n, lp, r0, rdiff, herr, fv, ra);
    checks++;
    if (n != 2 || rd[0] !== ref_mem[512] || rd[1] !== ref_mem[513]) begin
      failures++; $display("FAIL reset_mid_reread beats=%0d got %h,%h required %h,%h", n, rd[0], rd[1], ref_mem[512], ref_mem[513]);
    end
  endtask

  task automatic test_random();
    logic [1:0] resp, r0, burst;
    int n, lp, rdiff, herr;
    logic fv, ra;
    logic [31:0] addr;
    logic [7:0] len;
    for (int t = 0; t < 20; t++) begin
      addr  = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(0, 3))};
      len   = 8'($urandom_range(0, 15));
      burst = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
      for (int i = 0; i <= int'(len); i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      axi_write(addr, len, burst, int'(len) + 1, 1'b1, resp);
      model_write(addr, len, burst, int'(len) + 1);
      checks++;
      if (resp !== 2'b00) begin failures++; $display("FAIL random_bresp iter %0d BRESP=%b required 00", t, resp); end
      addr  = addr - 32'(4 * $urandom_range(0, 3));
      len   = 8'($urandom_range(0, 15));
      burst = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
      axi_read(addr, len, burst, 2, n, lp, r0, rdiff, herr, fv, ra);
      checks++;
      if (n != int'(len) + 1 || lp != int'(len) + 1 || r0 !== 2'b00 || herr != 0) begin
        failures++; $display("FAIL random_read_shape iter %0d beats=%0d rlast_at=%0d RRESP=%b hold_errs=%0d required %0d/%0d/00/0",
                             t, n, lp, r0, herr, int'(len) + 1, int'(len) + 1);
      end
      for (int i = 0; i < n && i <= int'(len); i++) begin
        checks++;
        if (rd[i] !== ref_mem[beat_word(addr, burst, i)]) begin
          failures++; $display("FAIL random_rdata iter %0d beat %0d got %h required %h", t, i, rd[i], ref_mem[beat_word(addr, burst, i)]);
        end
      end
    end
  endtask

  initial begin
    ARESETn = 1'b0;
    AWADDR = '0; AWLEN = '0; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARBURST = 2'b01; ARVALID = 1'b0; RREADY = 1'b0;
    #1;
    test_reset();
    test_fill();
    test_basic_incr();
    test_strobe();
    test_long_toggle();
    test_wrap_fixed();
    test_wlast_mismatch();
    test_reserved();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
